// File: rtl/host_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : host_packet_fifo
//  Purpose  : Byte-in / 32-bit-word-out FIFO for the host packet stream.
//             First byte of each word lands in bits [31:24]. Only complete
//             words are counted or readable; partial words stay pending.
//  Revision : 1.0  initial release
// ============================================================================
module host_packet_fifo #(
   parameter int DEPTH_BYTES = 2048,
   parameter int DEPTH_WORDS = DEPTH_BYTES / 4,
   parameter int COUNT_W     = 10
) (
   input  logic               clk100,
   input  logic               rst,
   input  logic [7:0]         din,
   input  logic               wr_en,
   input  logic               rd_en,
   output logic [31:0]        dout,
   output logic               full,
   output logic               empty,
   output logic               valid,
   output logic [COUNT_W-1:0] rd_data_count
);

   localparam int BA_W = $clog2(DEPTH_BYTES);   // byte address bits
   localparam int WA_W = $clog2(DEPTH_WORDS);   // word address bits

   localparam logic [BA_W:0] C_DEPTH_BYTES = DEPTH_BYTES[BA_W:0];
   localparam logic [BA_W:0] C_WR_INC      = {{BA_W{1'b0}}, 1'b1};
   localparam logic [WA_W:0] C_RD_INC      = {{WA_W{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit above the address bits
   logic [BA_W:0]        wr_ptr_q, wr_ptr_d;
   logic [WA_W:0]        rd_ptr_q, rd_ptr_d;
   logic [31:0]          dout_q, dout_d;
   logic                 valid_q, valid_d;

   logic [31:0]          mem [DEPTH_WORDS];

   logic [BA_W:0]        w_stored_bytes;
   logic [COUNT_W-1:0]   w_count;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_wr_accept;
   logic                 w_rd_accept;
   logic [WA_W-1:0]      w_wr_idx;
   logic [1:0]           w_wr_lane;
   logic [WA_W-1:0]      w_rd_idx;

   // Flags and count derived purely from the pointer registers
   always_comb begin
      w_stored_bytes = wr_ptr_q - {rd_ptr_q, 2'b00};
      w_count        = COUNT_W'(wr_ptr_q >> 2) - COUNT_W'(rd_ptr_q);
      w_full         = (w_stored_bytes == C_DEPTH_BYTES);
      w_empty        = (w_count == '0);
      w_wr_accept    = wr_en & ~w_full;
      w_rd_accept    = rd_en & ~w_empty;
      w_wr_idx       = wr_ptr_q[BA_W-1:2];
      w_wr_lane      = wr_ptr_q[1:0];
      w_rd_idx       = rd_ptr_q[WA_W-1:0];
   end

   // Next-state for pointers and the registered read port
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      if (w_wr_accept) begin
         wr_ptr_d = wr_ptr_q + C_WR_INC;
      end
      if (w_rd_accept) begin
         rd_ptr_d = rd_ptr_q + C_RD_INC;
         dout_d   = mem[w_rd_idx];
         valid_d  = 1'b1;
      end
   end

   // Pointer / output registers, cleared asynchronously
   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= 32'h0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
      end
   end

   // Byte-lane write into word storage; earliest byte goes to the top lane.
   // The word being filled never aliases the word being read: that would
   // require the FIFO to be both empty and full.
   always_ff @(posedge clk100) begin
      if (w_wr_accept) begin
         case (w_wr_lane)
            2'd0:    mem[w_wr_idx][31:24] <= din;
            2'd1:    mem[w_wr_idx][23:16] <= din;
            2'd2:    mem[w_wr_idx][15:8]  <= din;
            default: mem[w_wr_idx][7:0]   <= din;
         endcase
      end
   end

   assign dout          = dout_q;
   assign valid         = valid_q;
   assign full          = w_full;
   assign empty         = w_empty;
   assign rd_data_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_host_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_host_packet_fifo
//  Purpose  : Scoreboard bench for host_packet_fifo. Completed words are
//             queued as bytes are accepted and popped when reads are seen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_host_packet_fifo;

   localparam int DEPTH_BYTES = 2048;
   localparam int COUNT_W     = 10;

   logic               clk100 = 1'b0;
   logic               rst    = 1'b0;
   logic [7:0]         din    = 8'h0;
   logic               wr_en  = 1'b0;
   logic               rd_en  = 1'b0;
   logic [31:0]        dout;
   logic               full;
   logic               empty;
   logic               valid;
   logic [COUNT_W-1:0] rd_data_count;

   host_packet_fifo #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .DEPTH_WORDS (DEPTH_BYTES / 4),
      .COUNT_W     (COUNT_W)
   ) u_dut (
      .clk100        (clk100),
      .rst           (rst),
      .din           (din),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .dout          (dout),
      .full          (full),
      .empty         (empty),
      .valid         (valid),
      .rd_data_count (rd_data_count)
   );

   always #5 clk100 = ~clk100;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [31:0] sb_q[$];
   int          m_bytes = 0;      // stored bytes including pending partial
   int          m_nb    = 0;      // bytes in the pending partial word
   logic [31:0] m_part  = 32'h0;
   logic [31:0] m_dout  = 32'h0;
   logic        m_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_bytes = 0;
      m_nb    = 0;
      m_part  = 32'h0;
      m_dout  = 32'h0;
      m_valid = 1'b0;
   endtask

   // One clock cycle of stimulus followed by a full output comparison
   task automatic cycle(input logic w, input logic [7:0] b, input logic r);
      logic acc_w, acc_r;
      @(negedge clk100);
      wr_en = w;
      din   = b;
      rd_en = r;
      acc_w = w && rst && (m_bytes != DEPTH_BYTES);
      acc_r = r && rst && (m_bytes >= 4);
      @(posedge clk100);
      #1;
      m_valid = 1'b0;
      if (acc_r) begin
         m_dout  = sb_q.pop_front();
         m_valid = 1'b1;
         m_bytes = m_bytes - 4;
      end
      if (acc_w) begin
         m_part  = {m_part[23:0], b};
         m_nb++;
         m_bytes++;
         if (m_nb == 4) begin
            sb_q.push_back(m_part);
            m_nb = 0;
         end
      end
      chk("valid", {31'b0, valid}, {31'b0, m_valid});
      chk("dout",  dout, m_dout);
      chk("count", {22'b0, rd_data_count}, 32'(m_bytes / 4));
      chk("empty", {31'b0, empty}, {31'b0, (m_bytes < 4)});
      chk("full",  {31'b0, full},  {31'b0, (m_bytes == DEPTH_BYTES)});
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_w;
      logic [7:0]  n8;
      int          cnt;

      // Reset state
      model_reset();
      #1;
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_full",  {31'b0, full},  32'd0);
      chk("rst_count", {22'b0, rd_data_count}, 32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_dout",  dout, 32'h0);
      // rd_en / wr_en held while in reset: nothing moves
      @(negedge clk100);
      rd_en = 1'b1;
      wr_en = 1'b1;
      @(posedge clk100);
      #1;
      chk("inrst_valid", {31'b0, valid}, 32'd0);
      chk("inrst_count", {22'b0, rd_data_count}, 32'd0);
      @(negedge clk100);
      rst   = 1'b1;
      rd_en = 1'b0;
      wr_en = 1'b0;

      // Single word
      cycle(1, 8'h11, 0);
      cycle(1, 8'h22, 0);
      cycle(1, 8'h33, 0);
      cycle(1, 8'h44, 0);
      chk("w1_count", {22'b0, rd_data_count}, 32'd1);
      cycle(0, 8'h00, 1);
      chk("w1_dout", dout, 32'h11223344);
      cycle(0, 8'h00, 0);
      chk("w1_valid_drop", {31'b0, valid}, 32'd0);

      // Partial word is not readable
      cycle(1, 8'hAA, 0);
      cycle(1, 8'hBB, 0);
      cycle(1, 8'hCC, 0);
      cycle(0, 8'h00, 1);
      chk("part_dout_hold", dout, 32'h11223344);
      cycle(1, 8'hDD, 0);
      cycle(0, 8'h00, 1);
      chk("part_dout", dout, 32'hAABBCCDD);

      // Fill to capacity
      for (int i = 0; i < DEPTH_BYTES; i++) cycle(1, 8'(i), 0);
      chk("fill_full",  {31'b0, full}, 32'd1);
      chk("fill_count", {22'b0, rd_data_count}, 32'd512);
      cycle(1, 8'hFF, 0);
      chk("fill_extra_count", {22'b0, rd_data_count}, 32'd512);
      for (int n = 0; n < DEPTH_BYTES / 4; n++) begin
         cycle(0, 8'h00, 1);
         n8    = 8'(4 * n);
         exp_w = {n8, n8 + 8'd1, n8 + 8'd2, n8 + 8'd3};
         chk("fill_word", dout, exp_w);
         if (n == 0) chk("fill_full_drop", {31'b0, full}, 32'd0);
      end
      chk("drain_empty", {31'b0, empty}, 32'd1);

      // Steady-state streaming across the pointer wrap
      for (int i = 0; i < 1000; i++) cycle(1, 8'(i * 7 + 3), 0);
      for (int i = 0; i < 5000; i++) begin
         cycle(1, 8'(i * 13 + 5), (i % 4) == 0);
         cnt = int'(rd_data_count);
         chk("stream_count_band", {31'b0, (cnt >= 249 && cnt <= 251)}, 32'd1);
         chk("stream_no_empty",   {31'b0, empty}, 32'd0);
         chk("stream_no_full",    {31'b0, full},  32'd0);
      end
      while (m_bytes >= 4) cycle(0, 8'h00, 1);

      // Mid-stream reset with 10 words plus 2 bytes stored
      for (int i = 0; i < 42; i++) cycle(1, 8'(i + 8'h50), 0);
      chk("pre_rst_count", {22'b0, rd_data_count}, 32'd10);
      cycle(0, 8'h00, 1);
      @(negedge clk100);
      rst   = 1'b0;
      rd_en = 1'b1;
      wr_en = 1'b1;
      #1;
      model_reset();
      chk("mrst_empty", {31'b0, empty}, 32'd1);
      chk("mrst_full",  {31'b0, full},  32'd0);
      chk("mrst_count", {22'b0, rd_data_count}, 32'd0);
      chk("mrst_valid", {31'b0, valid}, 32'd0);
      chk("mrst_dout",  dout, 32'h0);
      @(posedge clk100);
      #1;
      chk("mrst_hold_valid", {31'b0, valid}, 32'd0);
      chk("mrst_hold_count", {22'b0, rd_data_count}, 32'd0);
      @(negedge clk100);
      rst   = 1'b1;
      rd_en = 1'b0;
      wr_en = 1'b0;
      cycle(1, 8'hDE, 0);
      cycle(1, 8'hAD, 0);
      cycle(1, 8'hBE, 0);
      cycle(1, 8'hEF, 0);
      cycle(0, 8'h00, 1);
      chk("fresh_word", dout, 32'hDEADBEEF);

      // Reads while empty are ignored
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1);
      chk("empty_rd_dout", dout, 32'hDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
